// File: rtl/alarm_trigger_if.sv
// -----------------------------------------------------------------------------
// alarm_trigger_if
//   Bundles the alarm-decision signals between the time/alarm sources and
//   the alarm_trigger block.
//
//   alarmData  [15:0] stored alarm time, BCD HH:MM
//   timeData   [15:0] current time, BCD HH:MM
//   secTick           one-cycle pulse once per second
//   alarmEn           alarm armed
//   stopBtn           stop request (debounced level)
//   snoozeBtn         snooze request (debounced level)
//   ring              alarm sounding
//   snoozing          snooze in progress
//   snoozeCnt  [2:0]  snoozes used in the current alarm event
//
//   master: the side that supplies time and buttons and consumes ring state.
//   slave : the alarm_trigger block itself.
// -----------------------------------------------------------------------------
interface alarm_trigger_if;
  logic [15:0] alarmData;
  logic [15:0] timeData;
  logic        secTick;
  logic        alarmEn;
  logic        stopBtn;
  logic        snoozeBtn;
  logic        ring;
  logic        snoozing;
  logic [2:0]  snoozeCnt;

  modport master (
    output alarmData, timeData, secTick, alarmEn, stopBtn, snoozeBtn,
    input  ring, snoozing, snoozeCnt
  );

  modport slave (
    input  alarmData, timeData, secTick, alarmEn, stopBtn, snoozeBtn,
    output ring, snoozing, snoozeCnt
  );
endinterface

// File: rtl/alarm_trigger.sv
// -----------------------------------------------------------------------------
// alarm_trigger
//   Decides when the alarm sounds. A rising edge of (alarmEn && time==alarm)
//   starts ringing; the ring silences itself after RING_SEC seconds, can be
//   stopped, or snoozed up to MAX_SNOOZE times for SNOOZE_SEC seconds each.
//
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    alarm_trigger_if.slave (time/alarm inputs, buttons, ring outputs)
//
//   Outputs ring, snoozing and snoozeCnt are all registered.
// -----------------------------------------------------------------------------
module alarm_trigger #(
  parameter int RING_SEC   = 60,   // 1..1023
  parameter int SNOOZE_SEC = 300,  // 1..1023
  parameter int MAX_SNOOZE = 3     // 0..7
) (
  input  logic          clk,
  input  logic          rst_n,
  alarm_trigger_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam logic [9:0] RING_LOAD   = 10'(RING_SEC);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SEC);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

  state_t     state_q, state_d;
  logic [9:0] timer_q, timer_d;
  logic [2:0] cnt_q,   cnt_d;
  logic       match_prev_q;
  logic       ring_q, snoozing_q;

  logic match;
  logic trigger;

  // Full 16-bit compare: a persisting match triggers only on its first cycle,
  // so the alarm fires once per minute, and loading an alarm equal to the
  // current time still produces an edge.
  assign match   = bus.alarmEn && (bus.timeData == bus.alarmData);
  assign trigger = match && !match_prev_q;

  // ---------------------------------------------------------------------------
  // Next-state / timer / snooze-count logic, in priority order.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;

    if (!bus.alarmEn) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else if (bus.stopBtn && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else if (bus.snoozeBtn && (state_q == RINGING) && (cnt_q < SNOOZE_MAX)) begin
      state_d = SNOOZE;
      timer_d = SNOOZE_LOAD;
      cnt_d   = cnt_q + 3'd1;
    end else if (bus.secTick && (state_q != IDLE)) begin
      // The last tick causes the transition instead of a decrement, so the
      // timer never reaches zero while it is in use.
      if (timer_q == 10'd1) begin
        if (state_q == RINGING) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          state_d = RINGING;
          timer_d = RING_LOAD;
        end
      end else if (timer_q >= 10'd2) begin
        timer_d = timer_q - 10'd1;
      end
    end else if ((state_q == IDLE) && trigger) begin
      state_d = RINGING;
      timer_d = RING_LOAD;
      cnt_d   = 3'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= 10'd0;
      cnt_q        <= 3'd0;
      match_prev_q <= 1'b0;
      ring_q       <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      match_prev_q <= match;
      // Outputs are decoded from the next state and registered, so they
      // change on the same edge as the state and are glitch-free.
      ring_q       <= (state_d == RINGING);
      snoozing_q   <= (state_d == SNOOZE);
    end
  end

  assign bus.ring      = ring_q;
  assign bus.snoozing  = snoozing_q;
  assign bus.snoozeCnt = cnt_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// -----------------------------------------------------------------------------
// tb_alarm_trigger
//   Directed self-checking bench for alarm_trigger with default parameters
//   (RING_SEC=60, SNOOZE_SEC=300, MAX_SNOOZE=3). Each scenario task drives
//   stimulus and compares {ring, snoozing, snoozeCnt} against hand-computed
//   values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alarm_trigger;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alarm_trigger_if bus ();

  alarm_trigger #(
    .RING_SEC   (60),
    .SNOOZE_SEC (300),
    .MAX_SNOOZE (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {ring, snoozing, snoozeCnt}.
  function automatic logic [4:0] outs();
    return {bus.ring, bus.snoozing, bus.snoozeCnt};
  endfunction

  // Advance one clock; return 1 ns after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n one-cycle secTick pulses, each followed by an idle cycle.
  task automatic tick(input int n);
    repeat (n) begin
      bus.secTick = 1'b1;
      step();
      bus.secTick = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.alarmData = 16'h0000;
    bus.timeData  = 16'h0000;
    bus.secTick   = 1'b0;
    bus.alarmEn   = 1'b0;
    bus.stopBtn   = 1'b0;
    bus.snoozeBtn = 1'b0;
    #12;
    n_checks++;
    if (outs() !== 5'b0_0_000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", outs(), 5'b0_0_000);
    end
    #5 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_ring();
    bus.alarmData = 16'h0730;
    bus.alarmEn   = 1'b1;
    bus.timeData  = 16'h0729;
    step();
    n_checks++;
    if (outs() !== 5'b0_0_000) begin
      n_fail++;
      $display("FAIL basic_pre_match: got %b expected %b", outs(), 5'b0_0_000);
    end
    bus.timeData = 16'h0730;
    step();
    n_checks++;
    if (outs() !== 5'b1_0_000) begin
      n_fail++;
      $display("FAIL basic_ring_latency: got %b expected %b", outs(), 5'b1_0_000);
    end
    tick(59);
    n_checks++;
    if (outs() !== 5'b1_0_000) begin
      n_fail++;
      $display("FAIL basic_ring_59_ticks: got %b expected %b", outs(), 5'b1_0_000);
    end
    tick(1);
    n_checks++;
    if (outs() !== 5'b0_0_000) begin
      n_fail++;
      $display("FAIL basic_timeout_60: got %b expected %b", outs(), 5'b0_0_000);
    end
    // Match persists for the rest of the minute: no re-trigger.
    tick(5);
    step(10);
    n_checks++;
    if (outs() !== 5'b0_0_000) begin
      n_fail++;
      $display("FAIL basic_no_retrigger: got %b expected %b", outs(), 5'b0_0_000);
    end
    bus.timeData = 16'h0731;
    step();
  endtask

  task automatic test_stop();
    // Buttons in IDLE have no effect.
    bus.snoozeBtn = 1'b1;
    bus.stopBtn   = 1'b1;
    step(2);
    bus.snoozeBtn = 1'b0;
    bus.stopBtn   = 1'b0;
    n_checks++;
    if (outs() !== 5'b0_0_000) begin
      n_fail++;
      $display("FAIL idle_buttons: got %b expected %b", outs(), 5'b0_0_000);
    end
    bus.timeData = 16'h0730;
    step();
    n_checks++;
    if (outs() !== 5'b1_0_000) begin
      n_fail++;
      $display("FAIL stop_ring_start: got %b expected %b", outs(), 5'b1_0_000);
    end
    // Stop outranks snooze when both are pressed.
    bus.stopBtn   = 1'b1;
    bus.snoozeBtn = 1'b1;
    step();
    bus.stopBtn   = 1'b0;
    bus.snoozeBtn = 1'b0;
    n_checks++;
    if (outs() !== 5'b0_0_000) begin
      n_fail++;
      $display("FAIL stop_pulse: got %b expected %b", outs(), 5'b0_0_000);
    end
    bus.timeData = 16'h0731;
    step();
  endtask

  task automatic test_snooze();
    bus.timeData = 16'h0730;
    step();
    bus.snoozeBtn = 1'b1;
    step();
    n_checks++;
    if (outs() !== 5'b0_1_001) begin
      n_fail++;
      $display("FAIL snooze_enter: got %b expected %b", outs(), 5'b0_1_001);
    end
    // Held button is ignored while snoozing.
    step(3);
    bus.snoozeBtn = 1'b0;
    n_checks++;
    if (outs() !== 5'b0_1_001) begin
      n_fail++;
      $display("FAIL snooze_held_btn: got %b expected %b", outs(), 5'b0_1_001);
    end
    tick(299);
    n_checks++;
    if (outs() !== 5'b0_1_001) begin
      n_fail++;
      $display("FAIL snooze_299_ticks: got %b expected %b", outs(), 5'b0_1_001);
    end
    tick(1);
    n_checks++;
    if (outs() !== 5'b1_0_001) begin
      n_fail++;
      $display("FAIL snooze_rering: got %b expected %b", outs(), 5'b1_0_001);
    end
  endtask

  task automatic test_snooze_limit();
    // Continues from ringing with snoozeCnt=1.
    for (int k = 2; k <= 3; k++) begin
      bus.snoozeBtn = 1'b1;
      step();
      bus.snoozeBtn = 1'b0;
      tick(300);
    end
    n_checks++;
    if (outs() !== 5'b1_0_011) begin
      n_fail++;
      $display("FAIL limit_third_rering: got %b expected %b", outs(), 5'b1_0_011);
    end
    bus.snoozeBtn = 1'b1;
    step(2);
    bus.snoozeBtn = 1'b0;
    n_checks++;
    if (outs() !== 5'b1_0_011) begin
      n_fail++;
      $display("FAIL limit_fourth_ignored: got %b expected %b", outs(), 5'b1_0_011);
    end
    // Ring timer was reloaded on re-ring; timeout clears the count.
    tick(60);
    n_checks++;
    if (outs() !== 5'b0_0_000) begin
      n_fail++;
      $display("FAIL limit_timeout_clear: got %b expected %b", outs(), 5'b0_0_000);
    end
    bus.timeData = 16'h0731;
    step();
  endtask

  task automatic test_disable_priority();
    bus.timeData = 16'h0730;
    step();
    bus.snoozeBtn = 1'b1;
    step();
    bus.snoozeBtn = 1'b0;
    n_checks++;
    if (outs() !== 5'b0_1_001) begin
      n_fail++;
      $display("FAIL disable_in_snooze: got %b expected %b", outs(), 5'b0_1_001);
    end
    bus.alarmEn = 1'b0;
    bus.stopBtn = 1'b1;
    step();
    bus.stopBtn = 1'b0;
    step(2);
    n_checks++;
    if (outs() !== 5'b0_0_000) begin
      n_fail++;
      $display("FAIL disable_to_idle: got %b expected %b", outs(), 5'b0_0_000);
    end
    bus.alarmEn = 1'b1;
    step();
    n_checks++;
    if (outs() !== 5'b1_0_000) begin
      n_fail++;
      $display("FAIL reenable_ring: got %b expected %b", outs(), 5'b1_0_000);
    end
  endtask

  task automatic test_async_reset();
    // Ringing here; assert reset between edges.
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 5'b0_0_000) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %b expected %b", outs(), 5'b0_0_000);
    end
    step(2);
    #3 rst_n = 1'b1;
    // Match still present: fresh rising edge after release rings again.
    step();
    n_checks++;
    if (outs() !== 5'b1_0_000) begin
      n_fail++;
      $display("FAIL reset_release_rering: got %b expected %b", outs(), 5'b1_0_000);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_ring();
    test_stop();
    test_snooze();
    test_snooze_limit();
    test_disable_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
